// File: rtl/max_pool_module_generic_pkg.sv
// Shared definitions for the max-pooling pipeline stage: widest supported pixel,
// an unsigned max helper, and elaboration-time parameter legality helpers.
package pool_pkg;

    localparam int unsigned MAX_BITWIDTH = 64;

    typedef logic [MAX_BITWIDTH-1:0] word_t;

    // Callers zero-extend narrower pixels, so the compare stays unsigned.
    function automatic word_t umax(input word_t a, input word_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic bit isMultiple(input int value, input int base);
        return (base > 0) && ((value % base) == 0);
    endfunction

    function automatic int idxWidth(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/max_pool_module_generic_if.sv
// Pixel stream into the pooling stage and pooled-maximum stream out of it.
interface max_pool_module_generic_if #(
    parameter int bitwidth = 8
);
    logic [bitwidth-1:0] data_in;
    logic                isValid;
    logic [bitwidth-1:0] data_out;
    logic                outValid;
    logic                outLast;

    modport master (
        output data_in, isValid,
        input  data_out, outValid, outLast
    );

    modport slave (
        input  data_in, isValid,
        output data_out, outValid, outLast
    );
endinterface

// File: rtl/max_pool_module_generic_pool_counter.sv
// Raster position generator: tracks where the next valid pixel falls inside
// its pooling window and block row, wrapping back to (0,0) after each frame.
module pool_counter
    import pool_pkg::*;
#(
    parameter int filterWidth = 3,
    parameter int imageWidth  = 6,
    parameter int imageHeight = 6,
    localparam int BLOCKS  = imageWidth / filterWidth,
    localparam int BROWS   = imageHeight / filterWidth,
    localparam int COL_W   = idxWidth(filterWidth),
    localparam int BLK_W   = idxWidth(BLOCKS),
    localparam int BROW_W  = idxWidth(BROWS)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             isValid_i,
    output logic             windowStart_o,
    output logic             windowEnd_o,
    output logic [BLK_W-1:0] blockIdx_o,
    output logic             frameEnd_o
);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(filterWidth - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLOCKS - 1);
    localparam logic [BROW_W-1:0] BROW_LAST = BROW_W'(BROWS - 1);

    logic [COL_W-1:0]  colInBlock_q, colInBlock_d;
    logic [BLK_W-1:0]  blockIdx_q,   blockIdx_d;
    logic [COL_W-1:0]  rowInBlock_q, rowInBlock_d;
    logic [BROW_W-1:0] blockRow_q,   blockRow_d;

    // Nested wrap: column within window, then block, then row within window, then block row.
    always_comb begin
        colInBlock_d = colInBlock_q;
        blockIdx_d   = blockIdx_q;
        rowInBlock_d = rowInBlock_q;
        blockRow_d   = blockRow_q;
        if (isValid_i) begin
            if (colInBlock_q == COL_LAST) begin
                colInBlock_d = '0;
                if (blockIdx_q == BLK_LAST) begin
                    blockIdx_d = '0;
                    if (rowInBlock_q == COL_LAST) begin
                        rowInBlock_d = '0;
                        blockRow_d   = (blockRow_q == BROW_LAST) ? '0 : blockRow_q + 1'b1;
                    end else begin
                        rowInBlock_d = rowInBlock_q + 1'b1;
                    end
                end else begin
                    blockIdx_d = blockIdx_q + 1'b1;
                end
            end else begin
                colInBlock_d = colInBlock_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            colInBlock_q <= '0;
            blockIdx_q   <= '0;
            rowInBlock_q <= '0;
            blockRow_q   <= '0;
        end else begin
            colInBlock_q <= colInBlock_d;
            blockIdx_q   <= blockIdx_d;
            rowInBlock_q <= rowInBlock_d;
            blockRow_q   <= blockRow_d;
        end
    end

    assign windowStart_o = (rowInBlock_q == '0) && (colInBlock_q == '0);
    assign windowEnd_o   = (rowInBlock_q == COL_LAST) && (colInBlock_q == COL_LAST);
    assign blockIdx_o    = blockIdx_q;
    assign frameEnd_o    = windowEnd_o && (blockIdx_q == BLK_LAST) && (blockRow_q == BROW_LAST);

endmodule

// File: rtl/max_pool_module_generic.sv
// Streaming non-overlapping max pooling: one running max per window of the
// current block row, emitted one cycle after the window's last pixel.
module max_pool_module_generic
    import pool_pkg::*;
#(
    parameter int bitwidth    = 8,
    parameter int filterWidth = 3,
    parameter int imageWidth  = 6,
    parameter int imageHeight = 6
) (
    input  logic clock,
    input  logic reset_n,
    max_pool_module_generic_if.slave bus
);

    localparam int BLOCKS = imageWidth / filterWidth;
    localparam int BLK_W  = idxWidth(BLOCKS);

    typedef logic [bitwidth-1:0] pixel_t;

    if (filterWidth < 2) begin : gFilterCheck
        $error("filterWidth must be at least 2");
    end
    if (!isMultiple(imageWidth, filterWidth)) begin : gWidthCheck
        $error("imageWidth must be a multiple of filterWidth");
    end
    if (!isMultiple(imageHeight, filterWidth)) begin : gHeightCheck
        $error("imageHeight must be a multiple of filterWidth");
    end
    if (bitwidth < 1 || bitwidth > MAX_BITWIDTH) begin : gBitwidthCheck
        $error("bitwidth out of supported range");
    end

    logic             windowStart;
    logic             windowEnd;
    logic             frameEnd;
    logic [BLK_W-1:0] blockIdx;

    pool_counter #(
        .filterWidth (filterWidth),
        .imageWidth  (imageWidth),
        .imageHeight (imageHeight)
    ) uCounter (
        .clock         (clock),
        .reset_n       (reset_n),
        .isValid_i     (bus.isValid),
        .windowStart_o (windowStart),
        .windowEnd_o   (windowEnd),
        .blockIdx_o    (blockIdx),
        .frameEnd_o    (frameEnd)
    );

    pixel_t acc_q [BLOCKS];
    pixel_t runningMax_d;
    pixel_t dataOut_q;
    logic   outValid_q;
    logic   outLast_q;

    assign runningMax_d = pixel_t'(umax(MAX_BITWIDTH'(acc_q[blockIdx]), MAX_BITWIDTH'(bus.data_in)));

    // A window start overwrites the slot so nothing leaks in from the previous block row.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < BLOCKS; i++) begin
                acc_q[i] <= '0;
            end
            dataOut_q  <= '0;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
        end else begin
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
            if (bus.isValid) begin
                acc_q[blockIdx] <= windowStart ? bus.data_in : runningMax_d;
                if (windowEnd) begin
                    dataOut_q  <= runningMax_d;
                    outValid_q <= 1'b1;
                    outLast_q  <= frameEnd;
                end
            end
        end
    end

    assign bus.data_out = dataOut_q;
    assign bus.outValid = outValid_q;
    assign bus.outLast  = outLast_q;

endmodule

// File: tb/tb_max_pool_module_generic.sv
// Self-checking bench for max_pool_module_generic against a frame-buffer model.
module tb_max_pool_module_generic;

    localparam int BW = 8;
    localparam int F  = 3;
    localparam int W  = 6;
    localparam int H  = 6;

    logic clock;
    logic reset_n;

    max_pool_module_generic_if #(.bitwidth(BW)) dutIf ();

    max_pool_module_generic #(
        .bitwidth    (BW),
        .filterWidth (F),
        .imageWidth  (W),
        .imageHeight (H)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (dutIf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: stores the frame, pools each window when its last pixel lands.
    logic [BW-1:0] img [H][W];
    int            pos;
    logic [BW-1:0] expData;
    logic          expValid;
    logic          expLast;

    task automatic stepCycle(input bit rstN, input bit valid, input logic [BW-1:0] v);
        int x;
        int y;
        logic [BW-1:0] m;
        expValid = 1'b0;
        expLast  = 1'b0;
        if (!rstN) begin
            pos     = 0;
            expData = '0;
        end else if (valid) begin
            x = pos % W;
            y = pos / W;
            img[y][x] = v;
            if ((x % F == F - 1) && (y % F == F - 1)) begin
                m = '0;
                for (int dy = 0; dy < F; dy++)
                    for (int dx = 0; dx < F; dx++)
                        if (img[y-dy][x-dx] > m) m = img[y-dy][x-dx];
                expData  = m;
                expValid = 1'b1;
                expLast  = (pos == W * H - 1);
            end
            pos = (pos + 1) % (W * H);
        end
        reset_n       = rstN;
        dutIf.isValid = valid;
        dutIf.data_in = v;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            stepCycle(1'b0, 1'b0, '0);
            checks++;
            if ({dutIf.outValid, dutIf.outLast, dutIf.data_out} !== {1'b0, 1'b0, 8'd0}) begin
                failures++;
                $display("[TB] FAIL reset_state: got valid=%b last=%b data=%0d, want 0/0/0",
                         dutIf.outValid, dutIf.outLast, dutIf.data_out);
            end
        end
    endtask

    task automatic test_sequential();
        logic [BW-1:0] seen [$];
        for (int p = 1; p <= 18; p++) begin
            stepCycle(1'b1, 1'b1, BW'(p));
            checks++;
            if ({dutIf.outValid, dutIf.outLast, dutIf.data_out} !== {expValid, expLast, expData}) begin
                failures++;
                $display("[TB] FAIL seq pixel %0d: got valid=%b last=%b data=%0d, want valid=%b last=%b data=%0d",
                         p, dutIf.outValid, dutIf.outLast, dutIf.data_out, expValid, expLast, expData);
            end
            if (dutIf.outValid === 1'b1) seen.push_back(dutIf.data_out);
        end
        checks++;
        if (seen.size() != 2 || seen[0] !== 8'd15 || seen[1] !== 8'd18) begin
            failures++;
            $display("[TB] FAIL seq_outputs: got %0d pulses, want 2 pulses of 15 and 18", seen.size());
        end
    endtask

    task automatic test_bubble();
        int lastCount = 0;
        for (int p = 19; p <= 36; p++) begin
            stepCycle(1'b1, 1'b1, BW'(p));
            checks++;
            if ({dutIf.outValid, dutIf.outLast, dutIf.data_out} !== {expValid, expLast, expData}) begin
                failures++;
                $display("[TB] FAIL bubble pixel %0d: got valid=%b last=%b data=%0d, want valid=%b last=%b data=%0d",
                         p, dutIf.outValid, dutIf.outLast, dutIf.data_out, expValid, expLast, expData);
            end
            if (dutIf.outLast === 1'b1 && dutIf.data_out === 8'd36) lastCount++;
            if (p == 19) begin
                stepCycle(1'b1, 1'b0, 'x);
                checks++;
                if ({dutIf.outValid, dutIf.outLast} !== 2'b00) begin
                    failures++;
                    $display("[TB] FAIL bubble_idle: got valid=%b last=%b, want 0/0",
                             dutIf.outValid, dutIf.outLast);
                end
            end
        end
        checks++;
        if (lastCount != 1) begin
            failures++;
            $display("[TB] FAIL bubble_last: got %0d last pulses with 36, want 1", lastCount);
        end
    endtask

    task automatic test_new_frame();
        logic [BW-1:0] v;
        logic [BW-1:0] firstMax;
        bit            gotFirst;
        for (int p = 0; p < W * H; p++) begin
            v = (p == 0) ? 8'd37 : (p == 1) ? 8'd38 : 8'd250;
            stepCycle(1'b1, 1'b1, v);
            checks++;
            if ({dutIf.outValid, dutIf.outLast, dutIf.data_out} !== {expValid, expLast, expData}) begin
                failures++;
                $display("[TB] FAIL frameA pos %0d: got valid=%b last=%b data=%0d, want valid=%b last=%b data=%0d",
                         p, dutIf.outValid, dutIf.outLast, dutIf.data_out, expValid, expLast, expData);
            end
        end
        gotFirst = 1'b0;
        firstMax = '0;
        for (int p = 0; p < W * H; p++) begin
            if ((p / W) < F && (p % W) < F) v = BW'(100 - ((p / W) * F + (p % W)));
            else v = 8'd50;
            stepCycle(1'b1, 1'b1, v);
            checks++;
            if ({dutIf.outValid, dutIf.outLast, dutIf.data_out} !== {expValid, expLast, expData}) begin
                failures++;
                $display("[TB] FAIL frameB pos %0d: got valid=%b last=%b data=%0d, want valid=%b last=%b data=%0d",
                         p, dutIf.outValid, dutIf.outLast, dutIf.data_out, expValid, expLast, expData);
            end
            if (dutIf.outValid === 1'b1 && !gotFirst) begin
                gotFirst = 1'b1;
                firstMax = dutIf.data_out;
            end
        end
        checks++;
        if (firstMax !== 8'd100) begin
            failures++;
            $display("[TB] FAIL reload_first_window: got %0d, want 100", firstMax);
        end
    endtask

    task automatic test_unsigned();
        logic [BW-1:0] v;
        logic [BW-1:0] firstMax;
        bit            gotFirst = 1'b0;
        firstMax = '0;
        for (int p = 0; p < W * H; p++) begin
            if ((p / W) < F && (p % W) < F) v = (p == W + 1) ? 8'd255 : 8'd0;
            else v = BW'($urandom_range(0, 254));
            stepCycle(1'b1, 1'b1, v);
            checks++;
            if ({dutIf.outValid, dutIf.outLast, dutIf.data_out} !== {expValid, expLast, expData}) begin
                failures++;
                $display("[TB] FAIL unsigned pos %0d: got valid=%b last=%b data=%0d, want valid=%b last=%b data=%0d",
                         p, dutIf.outValid, dutIf.outLast, dutIf.data_out, expValid, expLast, expData);
            end
            if (dutIf.outValid === 1'b1 && !gotFirst) begin
                gotFirst = 1'b1;
                firstMax = dutIf.data_out;
            end
        end
        checks++;
        if (firstMax !== 8'd255) begin
            failures++;
            $display("[TB] FAIL unsigned_max: got %0d, want 255", firstMax);
        end
    endtask

    task automatic test_mid_reset();
        int pulses = 0;
        for (int p = 0; p < 10; p++) stepCycle(1'b1, 1'b1, BW'($urandom_range(0, 255)));
        for (int i = 0; i < 2; i++) begin
            stepCycle(1'b0, 1'b1, 8'hFF);
            checks++;
            if ({dutIf.outValid, dutIf.outLast, dutIf.data_out} !== {1'b0, 1'b0, 8'd0}) begin
                failures++;
                $display("[TB] FAIL in_reset: got valid=%b last=%b data=%0d, want 0/0/0",
                         dutIf.outValid, dutIf.outLast, dutIf.data_out);
            end
        end
        stepCycle(1'b1, 1'b0, '0);
        checks++;
        if (dutIf.outValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL after_release: got valid=%b, want 0", dutIf.outValid);
        end
        for (int p = 0; p < W * H; p++) begin
            stepCycle(1'b1, 1'b1, BW'($urandom_range(0, 255)));
            checks++;
            if ({dutIf.outValid, dutIf.outLast, dutIf.data_out} !== {expValid, expLast, expData}) begin
                failures++;
                $display("[TB] FAIL post_reset pos %0d: got valid=%b last=%b data=%0d, want valid=%b last=%b data=%0d",
                         p, dutIf.outValid, dutIf.outLast, dutIf.data_out, expValid, expLast, expData);
            end
            if (dutIf.outValid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != (W / F) * (H / F)) begin
            failures++;
            $display("[TB] FAIL post_reset_pulses: got %0d, want %0d", pulses, (W / F) * (H / F));
        end
    endtask

    task automatic test_random();
        int  sent  = 0;
        int  guard = 0;
        bit  valid;
        while (sent < 3 * W * H && guard < 2000) begin
            valid = ($urandom_range(0, 3) != 0);
            stepCycle(1'b1, valid, valid ? BW'($urandom_range(0, 255)) : 'x);
            if (valid) sent++;
            guard++;
            checks++;
            if ({dutIf.outValid, dutIf.outLast, dutIf.data_out} !== {expValid, expLast, expData}) begin
                failures++;
                $display("[TB] FAIL random cycle %0d: got valid=%b last=%b data=%0d, want valid=%b last=%b data=%0d",
                         guard, dutIf.outValid, dutIf.outLast, dutIf.data_out, expValid, expLast, expData);
            end
        end
        checks++;
        if (sent < 3 * W * H) begin
            failures++;
            $display("[TB] FAIL random_budget: sent %0d pixels, want %0d", sent, 3 * W * H);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        dutIf.isValid = 1'b0;
        dutIf.data_in = '0;
        pos           = 0;
        expData       = '0;
        expValid      = 1'b0;
        expLast       = 1'b0;
        test_reset();
        test_sequential();
        test_bubble();
        test_new_frame();
        test_unsigned();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/max_pool_module_generic.md
# max_pool_module_generic

Streaming max-pooling block for the convolution/pooling pipeline. It accepts one unsigned pixel per valid cycle in raster order, with width `imageWidth` and height `imageHeight`. It pools non-overlapping `filterWidth`×`filterWidth` windows (stride = `filterWidth`) and emits one maximum per window as soon as the window's last pixel arrives. It sits directly after a convolution stage and tolerates bubbles (`isValid` low) on its input.

## Interface
- `bitwidth`, default 8: pixel width in bits, unsigned.
- `filterWidth`, default 3: pooling window edge and stride; must be ≥ 2.
- `imageWidth`, default 6: pixels per row; must be a multiple of `filterWidth`.
- `imageHeight`, default 6: rows per frame; must be a multiple of `filterWidth`.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `data_in` in `bitwidth`: input pixel, unsigned.
- `isValid` in 1: `data_in` is valid this cycle.
- `data_out` out `bitwidth`: pooled maximum.
- `outValid` out 1: `data_out` is valid; 1-cycle pulse per window.
- `outLast` out 1: high together with `outValid` for the final window of a frame.

## Operation
- Counters:
  - `colInBlock` (0..filterWidth-1)
  - `blockIdx` (0..imageWidth/filterWidth-1)
  - `rowInBlock` (0..filterWidth-1)
  - `blockRow` (0..imageHeight/filterWidth-1)
  - No dividers.
- Storage: accumulator array `acc[imageWidth/filterWidth]`, `bitwidth` bits each, holding the running max for each window in the current block row.
- On a cycle with `isValid`=1:
  - If `rowInBlock`==0 and `colInBlock`==0, set `acc[blockIdx]` to `data_in` (window start).
  - Otherwise set `acc[blockIdx]` to max(`acc[blockIdx]`, `data_in`), unsigned compare.
  - If `rowInBlock`==filterWidth-1 and `colInBlock`==filterWidth-1:
    - Register `data_out` = max(`acc[blockIdx]`, `data_in`) and `outValid`=1.
    - `outLast`=1 if `blockIdx` and `blockRow` are both at their maximums.
  - Advance counters in raster order, with nested wrap in this order: `colInBlock` → `blockIdx` → `rowInBlock` → `blockRow`. After the last pixel of a frame, all counters return to 0 and the next valid pixel starts a new frame.
- On a cycle with `isValid`=0:
  - No state change; `data_in` is ignored even if X/Z.
  - `outValid` and `outLast` are 0 next cycle.
- Outputs:
  - `data_out` holds its last value when `outValid`=0.
  - `outValid` and `outLast` are 0 in every cycle not produced by a window completion.

## Timing
- Latency: `data_out`/`outValid` are registered one clock after the rising edge that captured the window's final pixel.
- Throughput: one pixel per cycle. At most one output per cycle; outputs are at least `filterWidth` cycles apart.
- Back-pressure: none; the downstream stage must accept every `outValid` pulse.
- Reset (`reset_n`=0 at a rising edge):
  - All counters go to 0.
  - `acc` entries go to 0.
  - `data_out`=0, `outValid`=0, `outLast`=0.
  - Mid-frame reset discards partial windows; the next valid pixel is pixel (0,0) of a new frame.
- Reset has priority over `isValid`.

## Structure
- Shared package `pool_pkg`:
  - Pixel typedef `pixel_t` (logic [bitwidth-1:0] via parameterized usage).
  - Helper function `umax(a, b)`.
  - Parameter legality checks (multiple-of assertions) as elaboration-time `$error`.
- One natural sub-module: `pool_counter`, the raster position generator. It emits `windowStart`, `windowEnd`, `blockIdx` and `frameEnd` from `isValid`.
- The top holds `acc` and the output register.

## Test plan
- Defaults (W=H=6, F=3), pixels 1..18 continuous:
  - `outValid` pulses 1 cycle after pixel 15 (`data_out`=15).
  - `outValid` pulses 1 cycle after pixel 18 (`data_out`=18).
  - `outLast`=0 on both.
- Continue with pixel 19, then one cycle `isValid`=0 with `data_in`=X, then pixels 20..36:
  - The bubble causes no output and no state corruption.
  - Outputs are 33 and 36, with `outLast`=1 on 36.
- Pixels 37, 38 after frame end, then a 3×3 window containing descending values (max first):
  - The new frame starts at (0,0).
  - The first window max is correct, proving `acc` was reloaded and not carried over.
- Values 255 and 0 mixed in one window at `bitwidth`=8 → `data_out`=255 (unsigned compare, no sign issue).
- Assert `reset_n`=0 after 10 pixels, release, then feed a full frame → outputs match a fresh frame. `outValid` stays 0 during reset and in the cycle after release.
- Random stimulus with random `isValid` gaps against a reference model of pooled maxima → exact match on every output and on every `outLast` pulse.
